dlbf_coeffs_pp_cntrl: RTL and testbench

Parametrised host-side BRAM port-A controller for the DLBF coefficient store. It bridges the 32-bit AXI BRAM controller port to a BRAM_DW-wide coefficient BRAM split into two ping-pong banks, and routes byte addresses into 32-bit lanes. An internal CSR block with a swap state machine flips the active bank only at a consumer frame boundary, so the host can rewrite coefficients without tearing an in-flight frame.

---
 rtl/dlbf_coeffs_pkg.sv | 32 +++
 rtl/dlbf_coeffs_csr.sv | 102 ++++++++++
 rtl/dlbf_coeffs_pp_cntrl.sv | 122 ++++++++++++
 tb/tb_dlbf_coeffs_pp_cntrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dlbf_coeffs_pkg.sv
// Shared definitions for the DLBF coefficient ping-pong controller:
// CSR map, swap FSM states and geometry helpers.
package dlbf_coeffs_pkg;

    // CSR word offsets, taken from addr[4:2]
    localparam logic [2:0] CSR_CTRL       = 3'd0;
    localparam logic [2:0] CSR_STATUS     = 3'd1;
    localparam logic [2:0] CSR_WR_COUNT   = 3'd2;
    localparam logic [2:0] CSR_SWAP_COUNT = 3'd3;

    localparam int CTRL_SWAP_REQ  = 0;
    localparam int CTRL_RD_ACTIVE = 1;
    localparam int CTRL_IRQ_EN    = 2;

    localparam int STAT_BANK    = 0;
    localparam int STAT_PENDING = 1;
    localparam int STAT_IRQ     = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } swap_state_t;

    function automatic int calc_lanes(input int dw);
        return dw / 32;
    endfunction

    function automatic int calc_lsb(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/dlbf_coeffs_csr.sv
// Control/status registers, bank swap FSM, write/swap counters and irq.
module dlbf_coeffs_csr
    import dlbf_coeffs_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_wr,
    input  logic        data_wr,
    input  logic [2:0]  off,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    input  logic        frame_start,
    output logic        bank_sel,
    output logic        rd_active,
    output logic        swap_done,
    output logic        irq
);

    swap_state_t state;
    logic        irq_en;
    logic        irq_flag;
    logic [31:0] wr_count;
    logic [31:0] swap_count;
    logic        ctrl_wr;
    logic        swap_req_wr;
    logic        swap_fire;
    logic        irq_clr;
    logic        unused_wdata;

    assign ctrl_wr      = csr_wr && (off == CSR_CTRL);
    assign swap_req_wr  = ctrl_wr && wr_data[CTRL_SWAP_REQ];
    assign swap_fire    = (state == PENDING) && frame_start;
    assign irq_clr      = csr_wr && (off == CSR_STATUS) && wr_data[STAT_IRQ];
    assign irq          = irq_flag & irq_en;
    assign unused_wdata = ^wr_data[31:3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bank_sel   <= 1'b0;
            swap_done  <= 1'b0;
            rd_active  <= 1'b0;
            irq_en     <= 1'b0;
            irq_flag   <= 1'b0;
            wr_count   <= '0;
            swap_count <= '0;
        end else begin
            swap_done <= 1'b0;
            // A request written in IDLE arms the swap; frame_start in the
            // same cycle is not yet seen, so the swap waits for the next one.
            case (state)
                IDLE: begin
                    if (swap_req_wr)
                        state <= PENDING;
                end
                PENDING: begin
                    if (frame_start) begin
                        state      <= IDLE;
                        bank_sel   <= ~bank_sel;
                        swap_done  <= 1'b1;
                        swap_count <= swap_count + 32'd1;
                    end
                end
            endcase

            if (ctrl_wr) begin
                rd_active <= wr_data[CTRL_RD_ACTIVE];
                irq_en    <= wr_data[CTRL_IRQ_EN];
            end

            if (swap_fire)
                irq_flag <= 1'b1;
            else if (irq_clr)
                irq_flag <= 1'b0;

            if (swap_fire)
                wr_count <= '0;
            else if (data_wr && (wr_count != '1))
                wr_count <= wr_count + 32'd1;
        end
    end

    always_comb begin
        rd_data = '0;
        case (off)
            CSR_CTRL: begin
                rd_data[CTRL_SWAP_REQ]  = (state == PENDING);
                rd_data[CTRL_RD_ACTIVE] = rd_active;
                rd_data[CTRL_IRQ_EN]    = irq_en;
            end
            CSR_STATUS: begin
                rd_data[STAT_BANK]    = bank_sel;
                rd_data[STAT_PENDING] = (state == PENDING);
                rd_data[STAT_IRQ]     = irq_flag;
            end
            CSR_WR_COUNT:   rd_data = wr_count;
            CSR_SWAP_COUNT: rd_data = swap_count;
            default:        rd_data = '0;
        endcase
    end

endmodule

// File: rtl/dlbf_coeffs_pp_cntrl.sv
// Host BRAM port-A bridge: routes 32-bit host accesses into lanes of a
// ping-pong coefficient BRAM and returns BRAM/CSR reads through a fixed pipeline.
module dlbf_coeffs_pp_cntrl
    import dlbf_coeffs_pkg::*;
#(
    parameter int BRAM_DW = 64,
    parameter int BRAM_AW = 13,
    parameter int RD_LAT  = 1
) (
    input  logic                   BRAM_PORTA_clk,
    input  logic                   BRAM_PORTA_rstn,
    input  logic [19:0]            BRAM_PORTA_addr,
    input  logic [31:0]            BRAM_PORTA_din,
    output logic [31:0]            BRAM_PORTA_dout,
    input  logic                   BRAM_PORTA_en,
    input  logic                   BRAM_PORTA_we,
    input  logic                   frame_start,
    input  logic [BRAM_DW-1:0]     douta,
    output logic [BRAM_DW-1:0]     dina,
    output logic [BRAM_DW/8-1:0]   wea,
    output logic                   ena,
    output logic [BRAM_AW:0]       addra,
    output logic                   bank_sel,
    output logic                   swap_done,
    output logic                   irq
);

    localparam int LANES = calc_lanes(BRAM_DW);
    localparam int LSB   = calc_lsb(BRAM_DW);
    localparam int LW    = LSB - 2;
    localparam logic [BRAM_DW/8-1:0] WEA_LANE0 = {{(BRAM_DW/8-4){1'b0}}, 4'hF};

    logic                   clk;
    logic                   rst_n;
    logic                   is_csr;
    logic                   data_wr;
    logic                   csr_wr;
    logic                   rd_fire;
    logic                   rd_active;
    logic                   bank;
    logic [LW-1:0]          lane;
    logic [BRAM_AW-1:0]     word;
    logic [31:0]            csr_rd_data;
    logic [LANES-1:0][31:0] dina_lanes;
    logic [LANES-1:0][31:0] douta_lanes;
    logic                   unused_lo;

    assign clk       = BRAM_PORTA_clk;
    assign rst_n     = BRAM_PORTA_rstn;
    assign is_csr    = BRAM_PORTA_addr[19];
    assign data_wr   = BRAM_PORTA_en & BRAM_PORTA_we & ~is_csr;
    assign csr_wr    = BRAM_PORTA_en & BRAM_PORTA_we & is_csr;
    assign rd_fire   = BRAM_PORTA_en & ~BRAM_PORTA_we;
    assign lane      = BRAM_PORTA_addr[LSB-1:2];
    assign word      = BRAM_PORTA_addr[LSB+BRAM_AW-1:LSB];
    assign unused_lo = ^BRAM_PORTA_addr[1:0];

    if (LSB + BRAM_AW < 19) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^BRAM_PORTA_addr[18:LSB+BRAM_AW];
    end

    // Writes always hit the shadow bank; reads may be steered to the active one.
    assign bank  = (~BRAM_PORTA_we & rd_active) ? bank_sel : ~bank_sel;
    assign addra = {bank, word};
    assign ena   = BRAM_PORTA_en & ~is_csr;
    assign wea   = data_wr ? (WEA_LANE0 << {lane, 2'b00}) : '0;
    assign dina  = dina_lanes;
    assign douta_lanes = douta;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign dina_lanes[l] = (lane == LW'(l)) ? BRAM_PORTA_din : 32'h0;
    end

    dlbf_coeffs_csr u_csr (
        .clk         (clk),
        .rst_n       (rst_n),
        .csr_wr      (csr_wr),
        .data_wr     (data_wr),
        .off         (BRAM_PORTA_addr[4:2]),
        .wr_data     (BRAM_PORTA_din),
        .rd_data     (csr_rd_data),
        .frame_start (frame_start),
        .bank_sel    (bank_sel),
        .rd_active   (rd_active),
        .swap_done   (swap_done),
        .irq         (irq)
    );

    // Read metadata tracks the BRAM latency so the final stage lines up with douta.
    logic [RD_LAT:1]  vld_pipe;
    logic [RD_LAT:1]  csr_pipe;
    logic [LW-1:0]    lane_pipe [1:RD_LAT];
    logic [31:0]      cdat_pipe [1:RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe        <= '0;
            csr_pipe        <= '0;
            BRAM_PORTA_dout <= '0;
            for (int i = 1; i <= RD_LAT; i++) begin
                lane_pipe[i] <= '0;
                cdat_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[1]  <= rd_fire;
            csr_pipe[1]  <= is_csr;
            lane_pipe[1] <= lane;
            cdat_pipe[1] <= csr_rd_data;
            for (int i = 2; i <= RD_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                csr_pipe[i]  <= csr_pipe[i-1];
                lane_pipe[i] <= lane_pipe[i-1];
                cdat_pipe[i] <= cdat_pipe[i-1];
            end
            if (vld_pipe[RD_LAT])
                BRAM_PORTA_dout <= csr_pipe[RD_LAT] ? cdat_pipe[RD_LAT]
                                                    : douta_lanes[lane_pipe[RD_LAT]];
        end
    end

endmodule

// File: tb/tb_dlbf_coeffs_pp_cntrl.sv
// Scoreboard bench: two controllers (RD_LAT 2 and 3) on shared host stimulus,
// each with a behavioural BRAM; reads are checked by latency-aligned monitors.
module tb_dlbf_coeffs_pp_cntrl;

    localparam int DW  = 128;
    localparam int AW  = 13;
    localparam int RL2 = 2;
    localparam int RL3 = 3;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [19:0]     addr;
    logic [31:0]     din;
    logic            en, we, fs;
    logic [31:0]     dout2, dout3;
    logic [DW-1:0]   douta2, douta3, dina2, dina3;
    logic [DW/8-1:0] wea2, wea3;
    logic            ena2, ena3;
    logic [AW:0]     addra2, addra3;
    logic            bank2, bank3, sd2, sd3, irq2, irq3;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] q2[$];
    logic [31:0] q3[$];

    dlbf_coeffs_pp_cntrl #(.BRAM_DW(DW), .BRAM_AW(AW), .RD_LAT(RL2)) u2 (
        .BRAM_PORTA_clk(clk), .BRAM_PORTA_rstn(rstn), .BRAM_PORTA_addr(addr),
        .BRAM_PORTA_din(din), .BRAM_PORTA_dout(dout2), .BRAM_PORTA_en(en),
        .BRAM_PORTA_we(we), .frame_start(fs), .douta(douta2), .dina(dina2),
        .wea(wea2), .ena(ena2), .addra(addra2), .bank_sel(bank2),
        .swap_done(sd2), .irq(irq2)
    );

    dlbf_coeffs_pp_cntrl #(.BRAM_DW(DW), .BRAM_AW(AW), .RD_LAT(RL3)) u3 (
        .BRAM_PORTA_clk(clk), .BRAM_PORTA_rstn(rstn), .BRAM_PORTA_addr(addr),
        .BRAM_PORTA_din(din), .BRAM_PORTA_dout(dout3), .BRAM_PORTA_en(en),
        .BRAM_PORTA_we(we), .frame_start(fs), .douta(douta3), .dina(dina3),
        .wea(wea3), .ena(ena3), .addra(addra3), .bank_sel(bank3),
        .swap_done(sd3), .irq(irq3)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Behavioural BRAMs with the matching read latency
    logic [DW-1:0] mem2 [0:(1<<(AW+1))-1];
    logic [DW-1:0] mem3 [0:(1<<(AW+1))-1];
    logic [DW-1:0] rp2  [0:RL2-1];
    logic [DW-1:0] rp3  [0:RL3-1];

    always @(posedge clk) begin
        if (ena2) begin
            for (int b = 0; b < DW/8; b++)
                if (wea2[b]) mem2[addra2][b*8 +: 8] <= dina2[b*8 +: 8];
            rp2[0] <= mem2[addra2];
        end
        for (int i = 1; i < RL2; i++) rp2[i] <= rp2[i-1];
    end
    assign douta2 = rp2[RL2-1];

    always @(posedge clk) begin
        if (ena3) begin
            for (int b = 0; b < DW/8; b++)
                if (wea3[b]) mem3[addra3][b*8 +: 8] <= dina3[b*8 +: 8];
            rp3[0] <= mem3[addra3];
        end
        for (int i = 1; i < RL3; i++) rp3[i] <= rp3[i-1];
    end
    assign douta3 = rp3[RL3-1];

    // Monitors: dout is due RD_LAT edges after the edge that samples the read
    logic [RL2:0] vp2;
    logic [RL3:0] vp3;
    always @(posedge clk or negedge rstn)
        if (!rstn) vp2 <= '0; else vp2 <= {vp2[RL2-1:0], en & ~we};
    always @(posedge clk or negedge rstn)
        if (!rstn) vp3 <= '0; else vp3 <= {vp3[RL3-1:0], en & ~we};

    always @(negedge clk) begin
        if (vp2[RL2]) begin
            if (q2.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL rd2_unexpected: got %0h, required no read", dout2);
            end else chk("rd2", 128'(dout2), 128'(q2.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (vp3[RL3]) begin
            if (q3.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL rd3_unexpected: got %0h, required no read", dout3);
            end else chk("rd3", 128'(dout3), 128'(q3.pop_front()));
        end
    end

    task automatic drive(input logic e, input logic w, input logic [19:0] a,
                         input logic [31:0] d, input logic f);
        en = e; we = w; addr = a; din = d; fs = f;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 20'h0, 32'h0, 1'b0);
        repeat (n) step();
    endtask

    task automatic wr(input logic [19:0] a, input logic [31:0] d);
        drive(1'b1, 1'b1, a, d, 1'b0);
        step();
    endtask

    task automatic rd(input logic [19:0] a, input logic [31:0] e);
        drive(1'b1, 1'b0, a, 32'h0, 1'b0);
        q2.push_back(e);
        q3.push_back(e);
        step();
    endtask

    task automatic pulse_fs();
        drive(1'b0, 1'b0, 20'h0, 32'h0, 1'b1);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 1'b0, 20'h0, 32'h0, 1'b0);
        repeat (3) step();
        chk("rst_dout2", 128'(dout2), 128'h0);
        chk("rst_dout3", 128'(dout3), 128'h0);
        chk("rst_bank",  128'(bank2), 128'h0);
        chk("rst_swapd", 128'(sd2),   128'h0);
        chk("rst_irq",   128'(irq2),  128'h0);
        rstn = 1'b1;
        step();

        // Lane routing of a data write into the shadow bank
        drive(1'b1, 1'b1, 20'h00018, 32'hA5A5_0001, 1'b0);
        #1;
        chk("wr_addra", 128'(addra2), 128'h2001);
        chk("wr_wea",   128'(wea2),   128'h0F00);
        chk("wr_ena",   128'(ena2),   128'h1);
        chk("wr_dina",  128'(dina2),  {32'h0, 32'hA5A5_0001, 64'h0});
        step();
        rd(20'h00018, 32'hA5A5_0001);
        wr(20'h00024, 32'h1111_2222);
        rd(20'h00024, 32'h1111_2222);
        rd(20'h80008, 32'd2);

        // Basic swap
        drive(1'b1, 1'b1, 20'h80000, 32'h5, 1'b0);
        #1;
        chk("csr_ena", 128'(ena2), 128'h0);
        chk("csr_wea", 128'(wea2), 128'h0);
        step();
        rd(20'h80000, 32'h5);
        rd(20'h80004, 32'h2);
        idle(10);
        chk("pre_swap_bank", 128'(bank2), 128'h0);
        pulse_fs();
        chk("swap_done_hi", 128'(sd2),   128'h1);
        chk("swap_bank",    128'(bank2), 128'h1);
        chk("swap_irq",     128'(irq2),  128'h1);
        idle(1);
        chk("swap_done_lo", 128'(sd2),   128'h0);
        rd(20'h80004, 32'h5);
        rd(20'h8000C, 32'd1);
        rd(20'h80008, 32'd0);
        wr(20'h80004, 32'h4);
        chk("irq_w1c", 128'(irq2), 128'h0);
        rd(20'h80004, 32'h1);

        // swap_req together with frame_start does not swap
        drive(1'b1, 1'b1, 20'h80000, 32'h1, 1'b1);
        step();
        chk("same_cyc_bank",  128'(bank2), 128'h1);
        chk("same_cyc_swapd", 128'(sd2),   128'h0);
        rd(20'h80004, 32'h3);
        pulse_fs();
        chk("next_fs_bank",  128'(bank2), 128'h0);
        chk("next_fs_swapd", 128'(sd2),   128'h1);
        chk("irq_masked",    128'(irq2),  128'h0);
        rd(20'h80004, 32'h4);
        rd(20'h8000C, 32'd2);

        // Writes counted up to the swap; write in the swap cycle uncounted
        wr(20'h80000, 32'h1);
        wr(20'h00000, 32'h10);
        wr(20'h00004, 32'h20);
        wr(20'h00008, 32'h30);
        rd(20'h80008, 32'd3);
        drive(1'b1, 1'b1, 20'h0000C, 32'h40, 1'b1);
        #1;
        chk("swapcyc_addra", 128'(addra2), 128'h2000);
        chk("swapcyc_wea",   128'(wea2),   128'hF000);
        step();
        chk("swapcyc_bank", 128'(bank2), 128'h1);
        idle(1);
        rd(20'h80008, 32'd0);
        wr(20'h80000, 32'h2);
        rd(20'h0000C, 32'h40);
        rd(20'h00000, 32'h10);

        // Back-to-back alternating data/CSR reads from the active bank
        rd(20'h00018, 32'hA5A5_0001);
        rd(20'h80004, 32'h5);
        rd(20'h00024, 32'h1111_2222);
        rd(20'h80014, 32'h0);
        rd(20'h0001B, 32'hA5A5_0001);
        rd(20'h8000C, 32'd3);
        rd(20'h00008, 32'h30);
        rd(20'h80000, 32'h2);
        idle(6);

        // Reset while a swap is pending
        wr(20'h80000, 32'h1);
        idle(1);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_bank",  128'(bank2), 128'h0);
        chk("mid_rst_dout2", 128'(dout2), 128'h0);
        chk("mid_rst_dout3", 128'(dout3), 128'h0);
        chk("mid_rst_irq",   128'(irq2),  128'h0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        pulse_fs();
        chk("post_rst_bank",  128'(bank2), 128'h0);
        chk("post_rst_swapd", 128'(sd2),   128'h0);
        idle(1);
        rd(20'h80004, 32'h0);
        rd(20'h8000C, 32'h0);
        rd(20'h80000, 32'h0);
        idle(6);

        chk("q2_drained", 128'(q2.size()), 128'h0);
        chk("q3_drained", 128'(q3.size()), 128'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
